fifo_mem_ctrl: RTL
==================

Name: fifo_mem_ctrl

Overview:
Parametrised synchronous FIFO that combines the flop-based storage array, read/write pointer management, occupancy tracking and status flags in one block.
- Write side: push port. Read side: pop port with fixed 1-cycle registered read latency.
- Sticky overflow/underflow error flags, programmable almost-full/almost-empty levels, synchronous flush.
- Sits between a transaction producer and consumer as the standard outstanding-transaction buffer.

Parameters:
DATA_WIDTH, 32, transaction data width in bits (>=1)
OSTD_NUM, 8, FIFO depth in entries; power of two, >=2
AFULL_LEVEL, OSTD_NUM-2, almost_full asserts when count >= AFULL_LEVEL (1..OSTD_NUM)
AEMPTY_LEVEL, 2, almost_empty asserts when count <= AEMPTY_LEVEL (0..OSTD_NUM-1)
PTR_SIZE, $clog2(OSTD_NUM), address width; pointers are PTR_SIZE+1 bits (extra wrap bit)

Ports:
clk_in  input  1  clock; all logic on rising edge
sreset  input  1  synchronous reset, active high
flush  input  1  synchronous clear of pointers, count and read output; storage contents untouched
fifo_wenable  input  1  write request
data_in  input  DATA_WIDTH  write data
fifo_renable  input  1  read request
data_out  output  DATA_WIDTH  read data, registered
data_out_valid  output  1  one-cycle pulse, data_out holds a popped entry
full  output  1  count == OSTD_NUM
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_LEVEL
almost_empty  output  1  count <= AEMPTY_LEVEL
count  output  PTR_SIZE+1  current occupancy, 0..OSTD_NUM
overflow_err  output  1  sticky: write attempted while full and not accepted
underflow_err  output  1  sticky: read attempted while empty
err_clr  input  1  clears both sticky error flags

Behaviour:
- Reset (sreset=1 at clock edge; synchronous, active high):
  - Pointers = 0, count = 0, data_out = 0, data_out_valid = 0, both error flags = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Storage array is not reset.
  - sreset overrides flush, err_clr and all requests in the same cycle.
- Read accepted: rd_acc = fifo_renable && !empty.
- Write accepted: wr_acc = fifo_wenable && (!full || rd_acc). A write to a full FIFO is accepted when a read pops the same cycle.
- Empty FIFO with simultaneous read and write: write accepted, read rejected (no bypass), underflow_err set.
- On wr_acc: mem[wr_ptr[PTR_SIZE-1:0]] <= data_in; wr_ptr += 1, wrapping modulo 2*OSTD_NUM.
- On rd_acc: data_out <= mem[rd_ptr[PTR_SIZE-1:0]]; data_out_valid <= 1; rd_ptr += 1.
- Read latency: data appears exactly 1 cycle after the accepted request.
- No read accepted: data_out holds its last value; data_out_valid <= 0.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- Status flags are combinational decodes of the registered count (no extra latency).
  - full: pointers equal except the wrap bit.
  - empty: pointers fully equal.
- overflow_err set on fifo_wenable && full && !rd_acc.
- underflow_err set on fifo_renable && empty.
- Error flags hold until err_clr or sreset. A set event in the same cycle as err_clr wins (flag stays 1).
- flush: pointers and count -> 0, data_out_valid -> 0; requests in that cycle are ignored; error flags unchanged.
- Back-to-back reads and writes every cycle are supported at full throughput.

Optional Feature:
Macro FIFO_PEAK_EN.
- Defined:
  - Adds output peak_count (PTR_SIZE+1), a high-water mark of count.
  - Updated to count_next whenever count_next > peak_count.
  - Cleared by sreset and err_clr; not cleared by flush.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Default params: reset, then 8 writes 0xA0..0xA7 -> full=1, count=8, almost_full asserted once count reaches 6; 9th write -> overflow_err=1, count stays 8, mem unchanged.
- From full: 8 reads -> data_out = 0xA0..0xA7, each 1 cycle after its request with data_out_valid pulse; then empty=1; extra read -> underflow_err=1, data_out_valid=0.
- Full FIFO: simultaneous read+write of 0xB0 -> count stays 8, no overflow; drain -> 0xA1..0xA7, 0xB0.
- Empty FIFO: simultaneous read+write of 0xC0 -> underflow_err=1, count=1; next read returns 0xC0.
- Write/read 20 entries in steady stream (pointer wrap twice) -> in-order data, count oscillates 0..1; flush mid-stream with count=3 -> count=0, empty=1, errors unchanged; sreset mid-operation -> all outputs at reset values next cycle.
- With FIFO_PEAK_EN: fill to 5, drain to 1 -> peak_count=5; err_clr -> peak_count=1 (current count).

Source files
------------

// File: rtl/fifo_mem_ctrl_if.sv
// Push/pop, control and status bundle for fifo_mem_ctrl.
// With FIFO_PEAK_EN defined the bundle also carries the peak_count high-water mark.
interface fifo_mem_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OSTD_NUM   = 8
) ();
    localparam int unsigned PTR_SIZE = $clog2(OSTD_NUM);

    logic                  flush;
    logic                  fifo_wenable;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  fifo_renable;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_out_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [PTR_SIZE:0]     count;
    logic                  overflow_err;
    logic                  underflow_err;
`ifdef FIFO_PEAK_EN
    logic [PTR_SIZE:0]     peak_count;

    modport master (
        output flush, fifo_wenable, data_in, fifo_renable, err_clr,
        input  data_out, data_out_valid, full, empty, almost_full, almost_empty, count,
               overflow_err, underflow_err, peak_count
    );

    modport slave (
        input  flush, fifo_wenable, data_in, fifo_renable, err_clr,
        output data_out, data_out_valid, full, empty, almost_full, almost_empty, count,
               overflow_err, underflow_err, peak_count
    );
`else
    modport master (
        output flush, fifo_wenable, data_in, fifo_renable, err_clr,
        input  data_out, data_out_valid, full, empty, almost_full, almost_empty, count,
               overflow_err, underflow_err
    );

    modport slave (
        input  flush, fifo_wenable, data_in, fifo_renable, err_clr,
        output data_out, data_out_valid, full, empty, almost_full, almost_empty, count,
               overflow_err, underflow_err
    );
`endif
endinterface

// File: rtl/fifo_mem_ctrl.sv
// Synchronous flop-based FIFO with registered 1-cycle read, status flags and sticky errors.
// Optional high-water mark output enabled by defining FIFO_PEAK_EN.
module fifo_mem_ctrl #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned OSTD_NUM     = 8,
    parameter int unsigned AFULL_LEVEL  = OSTD_NUM - 2,
    parameter int unsigned AEMPTY_LEVEL = 2,
    parameter int unsigned PTR_SIZE     = $clog2(OSTD_NUM)
) (
    input logic            clk_in,
    input logic            sreset,
    fifo_mem_ctrl_if.slave bus
);
    localparam int unsigned CntW = PTR_SIZE + 1;

    logic [DATA_WIDTH-1:0] mem_q [OSTD_NUM];

    logic [CntW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic full, empty;
    logic rd_acc, wr_acc;
    logic ovf_set, udf_set;
    logic mem_we;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_SIZE] != rd_ptr_q[PTR_SIZE]) &&
                   (wr_ptr_q[PTR_SIZE-1:0] == rd_ptr_q[PTR_SIZE-1:0]);

    // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
    assign rd_acc  = bus.fifo_renable && !empty;
    assign wr_acc  = bus.fifo_wenable && (!full || rd_acc);
    assign ovf_set = bus.fifo_wenable && full && !rd_acc;
    assign udf_set = bus.fifo_renable && empty;
    assign mem_we  = wr_acc && !bus.flush && !sreset;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (bus.err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            dout_d   = '0;
        end else begin
            // Set events are applied after the clear so they win a same-cycle err_clr.
            if (ovf_set) ovf_d = 1'b1;
            if (udf_set) udf_d = 1'b1;

            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;

            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                dout_d   = mem_q[rd_ptr_q[PTR_SIZE-1:0]];
                dvalid_d = 1'b1;
            end

            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (sreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[PTR_SIZE-1:0]] <= bus.data_in;
        end
    end

    assign bus.data_out       = dout_q;
    assign bus.data_out_valid = dvalid_q;
    assign bus.full           = full;
    assign bus.empty          = empty;
    assign bus.almost_full    = (count_q >= CntW'(AFULL_LEVEL));
    assign bus.almost_empty   = (count_q <= CntW'(AEMPTY_LEVEL));
    assign bus.count          = count_q;
    assign bus.overflow_err   = ovf_q;
    assign bus.underflow_err  = udf_q;

`ifdef FIFO_PEAK_EN
    logic [CntW-1:0] peak_q, peak_d;

    // err_clr restarts the high-water mark from the occupancy being entered.
    always_comb begin
        peak_d = peak_q;
        if (bus.err_clr) begin
            peak_d = count_d;
        end else if (count_d > peak_q) begin
            peak_d = count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (sreset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign bus.peak_count = peak_q;
`endif

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk_in) disable iff (sreset)
        count_q <= CntW'(OSTD_NUM));
    a_count_ptrs: assert property (@(posedge clk_in) disable iff (sreset)
        count_q == CntW'(wr_ptr_q - rd_ptr_q));
    a_full_count: assert property (@(posedge clk_in) disable iff (sreset)
        full == (count_q == CntW'(OSTD_NUM)));
    a_empty_count: assert property (@(posedge clk_in) disable iff (sreset)
        empty == (count_q == '0));
`endif
endmodule
